// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit field positions and allocator FSM states.
package noc_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Control bits live at the top of every flit, payload fills the rest.
  function automatic int valid_pos(input int flit_w);
    return flit_w - 1;
  endfunction

  function automatic int head_pos(input int flit_w);
    return flit_w - 2;
  endfunction

  function automatic int tail_pos(input int flit_w);
    return flit_w - 3;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] j;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int off = 0; off < N; off++) begin
      j = IW'((int'(ptr_i) + off) % N);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/output_port_alloc.sv
// Output-port allocator: round-robin head arbitration, wormhole packet locking,
// credit-gated flit transfer with sticky credit-overflow error.
module output_port_alloc
  import noc_pkg::*;
#(
  parameter int FLIT_W = 17,
  parameter int N_IN   = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN-1:0]            req_i,
  input  logic [N_IN*FLIT_W-1:0]     flit_i,
  input  logic                       consume_i,
  output logic [N_IN-1:0]            grant_o,
  output logic [FLIT_W-1:0]          data_o,
  output logic [$clog2(DEPTH+1)-1:0] credit_o,
  output logic                       locked_o,
  output logic [$clog2(N_IN)-1:0]    owner_o,
  output logic                       err_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(N_IN);
  localparam int VB = valid_pos(FLIT_W);
  localparam int HB = head_pos(FLIT_W);
  localparam int TB = tail_pos(FLIT_W);

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [CW-1:0]       credit_q, credit_d;
  logic                err_q, err_d;
  logic [FLIT_W-1:0]   data_q, data_d;

  logic [N_IN-1:0]     head_req;
  logic [N_IN-1:0]     arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic [IW-1:0]       win_idx;
  logic [FLIT_W-1:0]   win_flit;
  logic                win_any;
  logic                send;
  logic [N_IN-1:0]     grant;

  // Only valid head flits may open a packet; body flits in IDLE are ignored.
  always_comb begin
    head_req = '0;
    for (int i = 0; i < N_IN; i++) begin
      head_req[i] = req_i[i] & flit_i[i*FLIT_W + VB] & flit_i[i*FLIT_W + HB];
    end
  end

  rr_arbiter #(.N(N_IN), .IW(IW)) u_arb (
    .req_i (head_req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Output logic: while LOCKED only the owner is looked at; sends need registered credit.
  always_comb begin
    win_idx  = (state_q == LOCKED) ? owner_q : arb_idx;
    win_flit = flit_i[int'(win_idx)*FLIT_W +: FLIT_W];
    win_any  = (state_q == LOCKED) ? (req_i[owner_q] & win_flit[VB]) : arb_any;
    send     = rst & win_any & (credit_q != '0);
    grant    = '0;
    if (send) grant[win_idx] = 1'b1;
  end

  // Next-state logic: any sent tail closes the packet, head bits while LOCKED are body.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (send) begin
      owner_d = win_idx;
      if (win_flit[TB]) begin
        state_d = IDLE;
        ptr_d   = (win_idx == IW'(N_IN - 1)) ? '0 : win_idx + IW'(1);
      end else begin
        state_d = LOCKED;
      end
    end
  end

  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    data_d   = send ? win_flit : '0;
    unique case ({send, consume_i})
      2'b10: credit_d = credit_q - CW'(1);
      2'b01: begin
        if (credit_q == CW'(DEPTH)) err_d = 1'b1;
        else                        credit_d = credit_q + CW'(1);
      end
      default: credit_d = credit_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q    <= '0;
      owner_q  <= '0;
      credit_q <= CW'(DEPTH);
      err_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      data_q   <= data_d;
    end
  end

  assign grant_o  = grant;
  assign data_o   = data_q;
  assign credit_o = credit_q;
  assign locked_o = (state_q == LOCKED);
  assign owner_o  = owner_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_output_port_alloc.sv
// Self-checking bench for output_port_alloc: directed scenarios plus randomized
// traffic against a packet-level reference model.
module tb_output_port_alloc;

  localparam int N = 4;
  localparam int W = 17;
  localparam int D = 4;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_i;
  logic [N*W-1:0]   flit_i;
  logic             consume_i;
  logic [N-1:0]     grant_o;
  logic [W-1:0]     data_o;
  logic [2:0]       credit_o;
  logic             locked_o;
  logic [1:0]       owner_o;
  logic             err_o;

  int passed = 0;
  int total  = 0;

  // Reference model state.
  bit             m_locked;
  int             m_owner;
  int             m_ptr;
  int             m_credit;
  bit             m_err;
  logic [W-1:0]   m_data;

  // Per-cycle results filled by step().
  logic [N-1:0]   s_gnt;
  logic [N-1:0]   e_gnt;

  output_port_alloc #(.FLIT_W(W), .N_IN(N), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .flit_i    (flit_i),
    .consume_i (consume_i),
    .grant_o   (grant_o),
    .data_o    (data_o),
    .credit_o  (credit_o),
    .locked_o  (locked_o),
    .owner_o   (owner_o),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input bit v, input bit h, input bit t, input int pl);
    logic [W-1:0] f;
    f = {v, h, t, 14'(pl)};
    return f;
  endfunction

  function automatic logic [W-1:0] get_flit(input logic [N*W-1:0] fl, input int i);
    return fl[i*W +: W];
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_credit = D; m_err = 0; m_data = '0;
  endtask

  // Which input the port should serve this cycle, or -1.
  function automatic int model_pick(input logic [N-1:0] req, input logic [N*W-1:0] fl);
    logic [W-1:0] f;
    if (m_credit == 0) return -1;
    if (m_locked) begin
      f = get_flit(fl, m_owner);
      return (req[m_owner] && f[W-1]) ? m_owner : -1;
    end
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      f = get_flit(fl, i);
      if (req[i] && f[W-1] && f[W-2]) return i;
    end
    return -1;
  endfunction

  task automatic model_update(input int win, input logic [N*W-1:0] fl, input logic cons);
    logic [W-1:0] f;
    m_data = '0;
    if (win >= 0) begin
      f       = get_flit(fl, win);
      m_data  = f;
      m_owner = win;
      if (f[W-3]) begin
        m_locked = 0;
        m_ptr    = (win + 1) % N;
      end else begin
        m_locked = 1;
      end
    end
    if (win >= 0 && !cons) m_credit--;
    else if (win < 0 && cons) begin
      if (m_credit == D) m_err = 1;
      else m_credit++;
    end
  endtask

  // Apply one cycle of stimulus; sample grant mid-cycle, then advance model past the edge.
  task automatic step(input logic [N-1:0] req, input logic [N*W-1:0] fl, input logic cons);
    int win;
    req_i = req; flit_i = fl; consume_i = cons;
    #2;
    win   = model_pick(req, fl);
    e_gnt = (win >= 0) ? N'(1 << win) : '0;
    s_gnt = grant_o;
    @(posedge clk);
    #1;
    model_update(win, fl, cons);
  endtask

  task automatic apply_reset();
    rst = 1'b0; req_i = '0; flit_i = '0; consume_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0; consume_i = 1'b0;
    req_i  = 4'b1111;
    flit_i = {mk(1,1,0,3), mk(1,1,0,2), mk(1,1,0,1), mk(1,1,0,0)};
    #3;
    total++; if (grant_o !== 4'b0000) $display("FAIL reset_grant got=%b want=0000", grant_o); else passed++;
    total++; if (credit_o !== 3'd4) $display("FAIL reset_credit got=%0d want=4", credit_o); else passed++;
    total++; if (data_o !== '0) $display("FAIL reset_data got=%h want=0", data_o); else passed++;
    total++; if (locked_o !== 1'b0 || err_o !== 1'b0 || owner_o !== 2'd0)
      $display("FAIL reset_flags locked=%b err=%b owner=%0d want 0/0/0", locked_o, err_o, owner_o);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b1; req_i = '0; flit_i = '0;
    model_reset();
  endtask

  // Input 1 sends head/body/tail while input 2 waits with a head, then input 2 opens its packet.
  task automatic test_packet_lock();
    logic [N-1:0] g_tab [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
    int           c_tab [4] = '{3, 2, 1, 0};
    bit           l_tab [4] = '{1, 1, 0, 1};
    logic [W-1:0] f1    [4];
    logic [W-1:0] sent;
    f1[0] = mk(1,1,0,11); f1[1] = mk(1,0,0,12); f1[2] = mk(1,0,1,13); f1[3] = mk(0,0,0,0);
    for (int c = 0; c < 4; c++) begin
      logic [N-1:0]   rq;
      logic [N*W-1:0] fl;
      rq = (c < 3) ? 4'b0110 : 4'b0100;
      fl = {mk(0,0,0,0), mk(1,1,0,21), f1[c], mk(0,0,0,0)};
      sent = (c < 3) ? f1[c] : mk(1,1,0,21);
      step(rq, fl, 1'b0);
      total++; if (s_gnt !== g_tab[c]) $display("FAIL lock_grant[%0d] got=%b want=%b", c, s_gnt, g_tab[c]); else passed++;
      total++; if (credit_o !== 3'(c_tab[c])) $display("FAIL lock_credit[%0d] got=%0d want=%0d", c, credit_o, c_tab[c]); else passed++;
      total++; if (locked_o !== l_tab[c]) $display("FAIL lock_locked[%0d] got=%b want=%b", c, locked_o, l_tab[c]); else passed++;
      total++; if (data_o !== sent) $display("FAIL lock_data[%0d] got=%h want=%h", c, data_o, sent); else passed++;
    end
  endtask

  // Continues from test_packet_lock: input 2 owns the port with zero credit.
  task automatic test_credit_stall();
    logic         cons_tab [6] = '{0, 0, 1, 0, 1, 0};
    logic [N-1:0] g_tab    [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100};
    int           c_tab    [6] = '{0, 0, 1, 0, 1, 0};
    for (int c = 0; c < 6; c++) begin
      logic [N*W-1:0] fl;
      fl = {mk(1,1,1,33), (c < 4) ? mk(1,0,0,32) : mk(1,0,1,34), mk(1,1,1,31), mk(1,1,1,30)};
      step(4'b1111, fl, cons_tab[c]);
      total++; if (s_gnt !== g_tab[c]) $display("FAIL stall_grant[%0d] got=%b want=%b", c, s_gnt, g_tab[c]); else passed++;
      total++; if (credit_o !== 3'(c_tab[c])) $display("FAIL stall_credit[%0d] got=%0d want=%0d", c, credit_o, c_tab[c]); else passed++;
      total++; if (owner_o !== 2'd2) $display("FAIL stall_owner[%0d] got=%0d want=2", c, owner_o); else passed++;
    end
    total++; if (locked_o !== 1'b0) $display("FAIL stall_unlock got=%b want=0", locked_o); else passed++;
  endtask

  task automatic test_rotation();
    logic [N-1:0]   g_tab [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N*W-1:0] fl;
    apply_reset();
    fl = {mk(1,1,1,43), mk(1,1,1,42), mk(1,1,1,41), mk(1,1,1,40)};
    for (int c = 0; c < 5; c++) begin
      step(4'b1111, fl, (c != 0));
      total++; if (s_gnt !== g_tab[c]) $display("FAIL rot_grant[%0d] got=%b want=%b", c, s_gnt, g_tab[c]); else passed++;
      total++; if (credit_o !== 3'd3) $display("FAIL rot_credit[%0d] got=%0d want=3", c, credit_o); else passed++;
      total++; if (data_o !== get_flit(fl, c % N)) $display("FAIL rot_data[%0d] got=%h want=%h", c, data_o, get_flit(fl, c % N)); else passed++;
    end
  endtask

  task automatic test_credit_edges();
    logic [N*W-1:0] fl;
    logic [N-1:0]   rq_tab [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic           cs_tab [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    int             c_tab  [8] = '{3, 2, 2, 3, 4, 4, 4, 4};
    bit             e_tab  [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    apply_reset();
    fl = {mk(0,0,0,0), mk(0,0,0,0), mk(0,0,0,0), mk(1,1,1,50)};
    for (int c = 0; c < 8; c++) begin
      step(rq_tab[c], fl, cs_tab[c]);
      total++; if (credit_o !== 3'(c_tab[c])) $display("FAIL edge_credit[%0d] got=%0d want=%0d", c, credit_o, c_tab[c]); else passed++;
      total++; if (err_o !== e_tab[c]) $display("FAIL edge_err[%0d] got=%b want=%b", c, err_o, e_tab[c]); else passed++;
    end
    total++; if (data_o[W-1] !== 1'b0) $display("FAIL edge_idle_valid got=%b want=0", data_o[W-1]); else passed++;
  endtask

  task automatic test_reset_mid_packet();
    logic [N*W-1:0] fl;
    apply_reset();
    step(4'b1000, {mk(1,1,0,60), {3{mk(0,0,0,0)}}}, 1'b0);
    step(4'b1000, {mk(1,0,0,61), {3{mk(0,0,0,0)}}}, 1'b0);
    step(4'b1000, {mk(1,0,0,62), {3{mk(0,0,0,0)}}}, 1'b0);
    total++; if (owner_o !== 2'd3 || credit_o !== 3'd1 || locked_o !== 1'b1)
      $display("FAIL mid_setup owner=%0d credit=%0d locked=%b want 3/1/1", owner_o, credit_o, locked_o);
    else passed++;
    req_i  = 4'b1001;
    flit_i = {mk(1,0,0,63), mk(0,0,0,0), mk(0,0,0,0), mk(1,1,1,64)};
    #2;
    rst = 1'b0;
    #1;
    total++; if (locked_o !== 1'b0 || credit_o !== 3'd4 || grant_o !== 4'b0000 || owner_o !== 2'd0)
      $display("FAIL mid_reset locked=%b credit=%0d grant=%b owner=%0d want 0/4/0000/0", locked_o, credit_o, grant_o, owner_o);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    step(4'b1001, {mk(1,1,0,65), mk(0,0,0,0), mk(0,0,0,0), mk(1,1,0,66)}, 1'b0);
    total++; if (s_gnt !== 4'b0001) $display("FAIL mid_after got=%b want=0001", s_gnt); else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0]   rq;
      logic [N*W-1:0] fl;
      if (c % 100 == 0) apply_reset();
      rq = N'($urandom);
      for (int i = 0; i < N; i++) begin
        fl[i*W +: W] = mk(($urandom_range(0, 7) != 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 16383)));
      end
      step(rq, fl, ($urandom_range(0, 2) == 0));
      total++; if (s_gnt !== e_gnt) $display("FAIL rnd_grant[%0d] got=%b want=%b", c, s_gnt, e_gnt); else passed++;
      total++; if (data_o !== m_data) $display("FAIL rnd_data[%0d] got=%h want=%h", c, data_o, m_data); else passed++;
      total++; if (credit_o !== 3'(m_credit)) $display("FAIL rnd_credit[%0d] got=%0d want=%0d", c, credit_o, m_credit); else passed++;
      total++; if (locked_o !== m_locked || owner_o !== 2'(m_owner) || err_o !== m_err)
        $display("FAIL rnd_state[%0d] locked=%b owner=%0d err=%b want %b/%0d/%b", c, locked_o, owner_o, err_o, m_locked, m_owner, m_err);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b0; req_i = '0; flit_i = '0; consume_i = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_packet_lock();
    test_credit_stall();
    test_rotation();
    test_credit_edges();
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/output_port_alloc.md
# output_port_alloc

Parametrised output-port allocator for the mesh NoC router: arbitrates N_IN input buffers competing for one output direction, locks the port to the winner for a whole wormhole packet (head to tail), and gates every flit on a downstream credit counter. It is the generalised successor of the fixed 4-input arbiter/credit-counter pair: width, input count and downstream buffer depth are parameters, and it adds round-robin fairness, packet locking and credit-overflow error detection. One instance sits on each router output, between the input buffers and the link register.

## Interface
- FLIT_W, 17: flit width; [FLIT_W-1] valid, [FLIT_W-2] head, [FLIT_W-3] tail, rest payload.
- N_IN, 4: number of competing inputs (2..8).
- DEPTH, 4: downstream buffer depth = reset credit value (1..15).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_i  in  N_IN  input i has a valid flit routed to this output.
- flit_i  in  N_IN*FLIT_W  front flit of each input; input i at [i*FLIT_W +: FLIT_W].
- consume_i  in  1  downstream freed one slot (credit return), one pulse per credit.
- grant_o  out  N_IN  one-hot (or zero); input i's front flit is taken this cycle (pop).
- data_o  out  FLIT_W  registered outgoing flit; valid bit 0 when idle.
- credit_o  out  $clog2(DEPTH+1)  current credit count.
- locked_o  out  1  port is owned by a packet (state LOCKED).
- owner_o  out  $clog2(N_IN)  current/last owner index.
- err_o  out  1  sticky: consume_i received at credit_o == DEPTH.

## Operation
- Send condition: candidate chosen, its flit valid, credit_q != 0. Only registered credit is used; a same-cycle consume_i does not enable a send at credit 0.
- FSM IDLE: candidates = inputs with req_i=1 and head bit=1. Round-robin pick starting at ptr, wrapping. On send: grant winner, owner=winner. Head with tail=1 (single-flit packet): stay IDLE, ptr=(winner+1) mod N_IN. Otherwise go LOCKED.
- Requests carrying body flits in IDLE are ignored (no grant).
- FSM LOCKED: only owner considered; others ignored regardless of req_i. Owner flit sent whenever valid and credit != 0. Sending tail: go IDLE, ptr=(owner+1) mod N_IN. Head bit seen from owner while LOCKED: treated as body (no relock).
- Credit: send only: -1; consume_i only: +1; both: unchanged. consume_i at DEPTH without send: hold DEPTH, set err_o. Underflow impossible (send gated).
- err_o clears only on reset.

## Timing
- grant_o combinational from req_i, flit_i, state, ptr, credit_q; same cycle as decision.
- data_o = granted flit, registered: appears 1 cycle after grant; data_o valid bit 0 in cycles following no grant.
- credit_o, locked_o, owner_o, state, ptr update on the edge ending the grant/consume cycle.
- Throughput: one flit per cycle while credits last; back-to-back packets from different inputs with no bubble (tail cycle -> IDLE, next head granted next cycle).
- Reset (any time, incl. mid-packet): state IDLE, ptr 0, owner_o 0, credit_o DEPTH, data_o 0, locked_o 0, err_o 0, grant_o 0 while rst low. Partial packet is abandoned; upstream/downstream flush is the system's job.

## Structure
- Shared package noc_pkg: flit bit-position localparams (VALID/HEAD/TAIL offsets as functions of FLIT_W), FSM enum {IDLE, LOCKED}.
- One sub-module: rr_arbiter #(N) — combinational request vector + ptr -> one-hot grant and encoded index; reused by other allocators.
- Credit counter and FSM inline in output_port_alloc.

## Test plan
- Reset, no traffic -> credit_o=4, data_o=0, grant_o=0, locked_o=0, err_o=0.
- Input 1 sends 3-flit packet (head, body, tail) while input 2 holds a head -> grant_o=0010 for 3 cycles, locked_o high 2 cycles, then grant_o=0100; data_o trails grants by 1 cycle; credit_o 4->3->2->1->0.
- Inputs 0..3 each send single-flit packets continuously, consume_i=1 each cycle -> grants rotate 0001,0010,0100,1000,0001; credit_o steady at 3 after first cycle.
- Locked packet, credit reaches 0 mid-packet, consume_i pulse -> grant_o stalls at 0 until cycle after consume_i, owner unchanged, other inputs never granted.
- Simultaneous send and consume_i at credit 2 -> credit stays 2; consume_i at credit 4 with no send -> credit 4, err_o=1 and stays 1.
- rst asserted low mid-packet (owner 3, credit 1) -> immediately IDLE, credit 4, grant_o 0; after release, a head on input 0 and 3 -> input 0 wins.
